// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer: aligns on frame_sync, collects one frame
// in shadow registers and publishes all four channel words together.
module tdm_demux4 #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 frame_sync,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 sync_error,
  output logic [CNT_WIDTH-1:0] frame_count
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  logic [WIDTH-1:0]     shadow0_q, shadow0_d;
  logic [WIDTH-1:0]     shadow1_q, shadow1_d;
  logic [WIDTH-1:0]     shadow2_q, shadow2_d;
  logic [WIDTH-1:0]     out0_q, out0_d;
  logic [WIDTH-1:0]     out1_q, out1_d;
  logic [WIDTH-1:0]     out2_q, out2_d;
  logic [WIDTH-1:0]     out3_q, out3_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 sync_error_q, sync_error_d;
  logic                 locked_q, locked_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    slot_d        = slot_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    shadow2_d     = shadow2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;
    frame_count_d = frame_count_q;
    frame_valid_d = 1'b0;
    sync_error_d  = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow0_d = din;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync mid-frame restarts the frame at this beat; earlier slots are simply overwritten later.
            sync_error_d = (slot_q != 2'd0);
            shadow0_d    = din;
            slot_d       = 2'd1;
          end else if (slot_q == 2'd0) begin
            sync_error_d = 1'b1;
            slot_d       = 2'd0;
            state_d      = HUNT;
          end else begin
            unique case (slot_q)
              2'd1: shadow1_d = din;
              2'd2: shadow2_d = din;
              default: begin
                // Slot 3 bypasses the shadow so the frame publishes one clock after its last beat.
                out0_d        = shadow0_q;
                out1_d        = shadow1_q;
                out2_d        = shadow2_q;
                out3_d        = din;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 1'b1;
              end
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments only; the shadow registers are
  // cleared on reset too, so a discarded partial frame can never leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
      frame_valid_q <= frame_valid_d;
      sync_error_q  <= sync_error_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign frame_valid = frame_valid_q;
  assign sync_error  = sync_error_q;
  assign locked      = locked_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed and random beats compared every cycle against a
// frame-collecting reference model built from a queue of received words.
module tb_tdm_demux4;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [WIDTH-1:0]     din;
  logic                 frame_sync;
  logic [WIDTH-1:0]     out0, out1, out2, out3;
  logic                 frame_valid, locked, sync_error;
  logic [CNT_WIDTH-1:0] frame_count;

  tdm_demux4 #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .frame_sync(frame_sync),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .locked(locked), .sync_error(sync_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Reference model: words of the frame in progress, plus the published frame.
  logic [WIDTH-1:0] m_cur[$];
  logic             m_lock;
  logic [WIDTH-1:0] m_out[4];
  logic             m_fv, m_se;
  int               m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_lock = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_fv  = 1'b0;
    m_se  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_beat(input logic fs, input logic [WIDTH-1:0] d);
    if (!m_lock) begin
      if (fs) begin
        m_cur.delete();
        m_cur.push_back(d);
        m_lock = 1'b1;
      end
    end else if (fs) begin
      if (m_cur.size() != 0) m_se = 1'b1;
      m_cur.delete();
      m_cur.push_back(d);
    end else if (m_cur.size() == 0) begin
      m_se   = 1'b1;
      m_lock = 1'b0;
    end else begin
      m_cur.push_back(d);
      if (m_cur.size() == 4) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_cur[i];
        m_cur.delete();
        m_fv  = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
      end
    end
  endtask

  task automatic check_all();
    check("out0", 32'(out0), 32'(m_out[0]));
    check("out1", 32'(out1), 32'(m_out[1]));
    check("out2", 32'(out2), 32'(m_out[2]));
    check("out3", 32'(out3), 32'(m_out[3]));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("sync_error", 32'(sync_error), 32'(m_se));
    check("locked", 32'(locked), 32'(m_lock));
    check("frame_count", 32'(frame_count), 32'(m_cnt));
    check("fv_se_exclusive", 32'(frame_valid & sync_error), 32'd0);
  endtask

  // One clock: inputs driven after the falling edge, model updated at the rising edge,
  // DUT sampled 1 time unit later.
  task automatic step(input logic rst, input logic iv, input logic fs, input logic [WIDTH-1:0] d);
    @(negedge clk);
    reset = rst; in_valid = iv; frame_sync = fs; din = d;
    @(posedge clk);
    cycle++;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (rst) model_reset();
    else if (iv) model_beat(fs, d);
    #1;
    check_all();
  endtask

  task automatic beat(input logic fs, input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, fs, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic frame(input logic [WIDTH-1:0] a, b, c, e);
    beat(1'b1, a); beat(1'b0, b); beat(1'b0, c); beat(1'b0, e);
  endtask

  int fv_total;
  int last_fv;
  int pos;
  logic fs_r;

  initial begin
    reset = 1'b1; in_valid = 1'b0; frame_sync = 1'b0; din = '0;
    model_reset();

    // Reset state, with a beat offered during reset that must be ignored.
    step(1'b1, 1'b1, 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Basic frame, then idle to see frame_valid drop and outputs hold.
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    idle(1);
    check("basic_out0", 32'(out0), 32'h11);
    check("basic_out3", 32'(out3), 32'h44);
    check("basic_count", 32'(frame_count), 32'd1);

    // Same frame with 2-cycle gaps between beats, from a fresh reset.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    beat(1'b1, 8'h11); idle(2);
    beat(1'b0, 8'h22); idle(2);
    beat(1'b0, 8'h33); idle(2);
    check("gap_hold_zero", 32'(out0), 32'h00);
    beat(1'b0, 8'h44);
    check("gap_fv", 32'(frame_valid), 32'd1);
    check("gap_out1", 32'(out1), 32'h22);
    idle(2);

    // Early sync on slot 2, then a clean frame A0..A3.
    beat(1'b1, 8'h51); beat(1'b0, 8'h52);
    beat(1'b1, 8'hA0);
    check("early_se", 32'(sync_error), 32'd1);
    check("early_hold", 32'(out0), 32'h11);
    beat(1'b0, 8'hA1); beat(1'b0, 8'hA2); beat(1'b0, 8'hA3);
    check("early_out0", 32'(out0), 32'hA0);
    check("early_out3", 32'(out3), 32'hA3);

    // Lost sync: slot-0 beat without frame_sync, then beats ignored until the next sync.
    beat(1'b0, 8'hEE);
    check("lost_se", 32'(sync_error), 32'd1);
    check("lost_unlocked", 32'(locked), 32'd0);
    check("lost_hold", 32'(out2), 32'hA2);
    beat(1'b0, 8'h01); beat(1'b0, 8'h02); beat(1'b0, 8'h03); beat(1'b0, 8'h04);
    frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);

    // Reset in the middle of a frame.
    beat(1'b1, 8'h55); beat(1'b0, 8'h66); beat(1'b0, 8'h77);
    step(1'b1, 1'b1, 1'b0, 8'h88);
    check("midrst_out0", 32'(out0), 32'h00);
    check("midrst_locked", 32'(locked), 32'd0);
    frame(8'h12, 8'h34, 8'h56, 8'h78);
    check("midrst_count", 32'(frame_count), 32'd1);

    // 256 back-to-back frames: counter wraps, pulses exactly 4 cycles apart.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    fv_total = 0;
    last_fv  = -1;
    for (int f = 0; f < 256; f++) begin
      for (int s = 0; s < 4; s++) begin
        beat(s == 0, 8'($urandom));
        if (frame_valid) begin
          if (last_fv >= 0) check("fv_spacing", 32'(cycle - last_fv), 32'd4);
          last_fv = cycle;
          fv_total++;
        end
      end
    end
    check("wrap_pulses", 32'(fv_total), 32'd256);
    check("wrap_count", 32'(frame_count), 32'd0);

    // Random stream: mostly aligned syncs with occasional misplaced or missing ones.
    pos = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
        pos = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        fs_r = (pos % 4 == 0);
        if ($urandom_range(0, 11) == 0) fs_r = ~fs_r;
        beat(fs_r, 8'($urandom));
        pos = fs_r ? 1 : pos + 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cycle);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side partner of the 4:1 channel multiplexer.
- Takes a time-division-multiplexed word stream and distributes the slots back to four parallel channel outputs. The stream repeats slots 0,1,2,3, and a frame_sync flag marks slot 0.
- Tracks frame alignment, double-buffers each frame so all four outputs update together, and reports lock, frame count and sync errors.

Parameters:
- WIDTH, 8, bit width of each channel word.
- CNT_WIDTH, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  din/frame_sync carry a beat this cycle.
- din  input  WIDTH  multiplexed channel word.
- frame_sync  input  1  high on the slot-0 beat of each frame; ignored when in_valid=0.
- out0  output  WIDTH  channel 0 word of the last complete frame.
- out1  output  WIDTH  channel 1 word of the last complete frame.
- out2  output  WIDTH  channel 2 word of the last complete frame.
- out3  output  WIDTH  channel 3 word of the last complete frame.
- frame_valid  output  1  one-cycle pulse when out0..out3 update.
- locked  output  1  high while in LOCKED state.
- sync_error  output  1  one-cycle pulse on an alignment violation.
- frame_count  output  CNT_WIDTH  number of completed frames, modulo 2^CNT_WIDTH.

Behaviour:
- Reset, synchronous and active-high, sampled on the rising clk edge:
  - out0..out3=0, frame_valid=0, locked=0, sync_error=0, frame_count=0.
  - Slot counter=0, shadow registers=0, state=HUNT.
  - Reset overrides a simultaneous beat. A partial frame is discarded and outputs return to 0.
- States:
  - HUNT: beats with frame_sync=0 are discarded, with no sync_error.
    - A beat with in_valid=1 and frame_sync=1 writes din to shadow0, sets slot=1 and moves to LOCKED.
  - LOCKED: each in_valid=1 beat writes din to shadow[slot]; slot increments modulo 4.
  - in_valid=0 cycles: no state, slot or shadow change, in either state.
- Alignment checks in LOCKED:
  - Beat with slot=0 and frame_sync=1: normal frame start.
  - Beat with slot=1..3 and frame_sync=1: early sync.
    - Pulse sync_error the next cycle and discard the partial frame.
    - Accept the beat as slot 0 (shadow0=din, slot=1). Stay LOCKED.
  - Beat with slot=0 and frame_sync=0: lost sync.
    - Pulse sync_error the next cycle, discard the beat and go to HUNT.
    - The outputs keep the last complete frame.
- Frame completion, on a slot-3 beat in LOCKED with frame_sync=0:
  - In the next cycle, out0..out3 load shadow0..2 plus the slot-3 din simultaneously.
  - frame_valid=1 for exactly that cycle.
  - frame_count increments by 1 and wraps from 2^CNT_WIDTH-1 to 0.
  - Latency from the slot-3 beat edge to valid outputs is one clock.
- Outputs are registered:
  - Between completions, out0..out3 hold their value. Partial-frame data never appears on them.
- Timing of locked, sync_error and frame_valid:
  - locked is registered and goes high the cycle after the HUNT sync beat.
  - sync_error and frame_valid are never both high in the same cycle.
- Back-to-back frames with in_valid held high give one frame_valid pulse every 4 cycles.

Test Plan:
- Reset then frame with sync on the first beat, din 0x11,0x22,0x33,0x44 at in_valid=1 -> frame_valid pulses once the cycle after 0x44; out0..3=0x11,0x22,0x33,0x44; frame_count=1; locked=1 from cycle 2; sync_error stays 0.
- Same frame with in_valid=0 gaps of 2 cycles between beats -> identical outputs; frame_valid only after the fourth valid beat; outputs stay 0 until then.
- While locked, frame_sync=1 on the slot-2 beat (din 0xA0), then 0xA1,0xA2,0xA3 -> sync_error pulses once; then frame_valid with out0..3=0xA0..0xA3; previous frame held until then.
- While locked, a slot-0 beat with frame_sync=0 -> sync_error pulses; locked=0 next cycle; out0..3 retain the prior frame; beats ignored until the next frame_sync.
- Stream 256 consecutive frames with CNT_WIDTH=8 -> frame_count wraps to 0 after frame 256; 256 frame_valid pulses total, spaced 4 cycles apart.
- Assert reset after the slot-2 beat -> next cycle all outputs 0, locked=0; the following frame starting with sync completes normally with frame_count=1.
